fft_seq: RTL and testbench

- Parametrised top-level sequencer for the banked in-place FFT. Generalises the fixed 32-point/4-bank control flow to any power-of-two size, bank count and stage count.
- Streams samples into the RAM banks over a valid/ready input, issues one start/done handshake per butterfly stage to the external stage engine, then streams results out over valid/ready with backpressure.
- Adds abort, a per-stage watchdog with sticky error, and an output skid buffer. None of these exist in the current fixed top level.

---
 rtl/fft_seq.sv | 185 ++++++++++++++++++
 tb/tb_fft_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_seq.sv
// rtl/fft_seq.sv - Load / per-stage handshake / unload sequencer for the banked in-place FFT.
// Adds abort, a per-stage watchdog with sticky error, and a 2-entry output skid buffer.
module fft_seq #(
  parameter int WORDSIZE   = 16,
  parameter int NUMSAMPLES = 32,
  parameter int NUMBANKS   = 4,
  parameter int ADDRSIZE   = 3,
  parameter int NUMSTAGES  = 5,
  parameter int STGW       = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUMBANKS*WORDSIZE-1:0] in_data,
  output logic                         ram_sel,
  output logic                         ram_wr_en,
  output logic [ADDRSIZE-1:0]          ram_wr_addr,
  output logic [NUMBANKS*WORDSIZE-1:0] ram_wr_data,
  output logic                         ram_rd_en,
  output logic [ADDRSIZE-1:0]          ram_rd_addr,
  input  logic [NUMBANKS*WORDSIZE-1:0] ram_rd_data,
  output logic                         stg_start,
  output logic [STGW-1:0]              stg_num,
  input  logic                         stg_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUMBANKS*WORDSIZE-1:0] out_data
);
  localparam int DW = NUMBANKS * WORDSIZE;
  localparam logic [ADDRSIZE:0] LAST_BEAT = (ADDRSIZE+1)'(NUMSAMPLES / NUMBANKS - 1);
  localparam logic [ADDRSIZE:0] ONE_A     = (ADDRSIZE+1)'(1);
  localparam logic [STGW-1:0]   LAST_STG  = STGW'(NUMSTAGES - 1);
  localparam logic [16:0]       TMO       = 17'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_UNLOAD, S_FIN, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDRSIZE:0] ld_addr_q, ld_addr_d;
  logic [ADDRSIZE:0] rd_addr_q, rd_addr_d;
  logic [ADDRSIZE:0] out_cnt_q, out_cnt_d;
  logic [STGW-1:0]   stg_num_q, stg_num_d;
  logic [15:0]       wdog_q, wdog_d;
  logic              error_q, error_d;
  logic              rd_pend_q, rd_pend_d;
  logic [1:0]        sk_cnt_q, sk_cnt_d;
  logic [DW-1:0]     sk0_q, sk0_d, sk1_q, sk1_d;
  logic              wr_fire, rd_fire, pop;
  logic [1:0]        base;

  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    rd_addr_d = rd_addr_q;
    out_cnt_d = out_cnt_q;
    stg_num_d = stg_num_q;
    wdog_d    = wdog_q;
    error_d   = error_q;
    sk0_d     = sk0_q;
    sk1_d     = sk1_q;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    pop       = (sk_cnt_q != 2'd0) && out_ready;
    // Skid entry 0 is the head; a capture lands just behind whatever survives this cycle's pop.
    base      = sk_cnt_q - {1'b0, pop};
    sk_cnt_d  = base + {1'b0, rd_pend_q};
    if (pop) sk0_d = sk1_q;
    if (rd_pend_q) begin
      if (base == 2'd0) sk0_d = ram_rd_data;
      else              sk1_d = ram_rd_data;
    end

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d   = S_LOAD;
          ld_addr_d = '0;
          rd_addr_d = '0;
          out_cnt_d = '0;
          stg_num_d = '0;
          error_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          wr_fire   = 1'b1;
          ld_addr_d = ld_addr_q + ONE_A;
          if (ld_addr_q == LAST_BEAT) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 16'd1;
        if (stg_done) begin
          if (stg_num_q == LAST_STG) state_d = S_UNLOAD;
          else begin
            stg_num_d = stg_num_q + STGW'(1);
            state_d   = S_ISSUE;
          end
        end else if ({1'b0, wdog_q} + 17'd2 >= TMO) begin
          // error becomes visible exactly TIMEOUT cycles after the stage's stg_start
          state_d = S_ERROR;
          error_d = 1'b1;
        end
      end
      S_UNLOAD: begin
        if (rd_addr_q <= LAST_BEAT && sk_cnt_d < 2'd2) begin
          rd_fire   = 1'b1;
          rd_addr_d = rd_addr_q + ONE_A;
        end
        if (pop) begin
          out_cnt_d = out_cnt_q + ONE_A;
          if (out_cnt_q == LAST_BEAT) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_pend_d = rd_fire;
    if (abort) begin
      state_d   = S_IDLE;
      error_d   = 1'b0;
      wr_fire   = 1'b0;
      rd_fire   = 1'b0;
      rd_pend_d = 1'b0;
      sk_cnt_d  = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ld_addr_q <= '0;
      rd_addr_q <= '0;
      out_cnt_q <= '0;
      stg_num_q <= '0;
      wdog_q    <= '0;
      error_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      sk_cnt_q  <= 2'd0;
      sk0_q     <= '0;
      sk1_q     <= '0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      rd_addr_q <= rd_addr_d;
      out_cnt_q <= out_cnt_d;
      stg_num_q <= stg_num_d;
      wdog_q    <= wdog_d;
      error_q   <= error_d;
      rd_pend_q <= rd_pend_d;
      sk_cnt_q  <= sk_cnt_d;
      sk0_q     <= sk0_d;
      sk1_q     <= sk1_d;
    end
  end

  assign busy        = !(state_q == S_IDLE || state_q == S_ERROR);
  assign done        = (state_q == S_FIN);
  assign error       = error_q;
  assign in_ready    = (state_q == S_LOAD) && !abort;
  assign ram_sel     = !(state_q == S_ISSUE || state_q == S_WAIT);
  assign ram_wr_en   = wr_fire;
  assign ram_wr_addr = ld_addr_q[ADDRSIZE-1:0];
  assign ram_wr_data = in_data;
  assign ram_rd_en   = rd_fire;
  assign ram_rd_addr = rd_addr_q[ADDRSIZE-1:0];
  assign stg_start   = (state_q == S_ISSUE) && !abort;
  assign stg_num     = stg_num_q;
  assign out_valid   = (sk_cnt_q != 2'd0);
  assign out_data    = sk0_q;

endmodule

// File: tb/tb_fft_seq.sv
// tb/tb_fft_seq.sv - Directed bench for fft_seq: a 32-point/4-bank build and a 64-point/8-bank build.
// Only one build is exercised at a time; use_b selects which one the RAM, engine and monitor follow.
module tb_fft_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, use_b = 1'b0, man_done = 1'b0;
  logic [63:0]  in_data = '0;
  logic [127:0] in_data_b;
  logic [127:0] ram_rd_data = '0;
  assign in_data_b = {in_data, in_data};

  logic a_busy, a_done, a_error, a_in_ready, a_ram_sel, a_wr_en, a_rd_en, a_stg_start, a_out_valid, a_stg_done;
  logic [2:0] a_wr_addr, a_rd_addr, a_stg_num;
  logic [63:0] a_wr_data, a_out_data;
  logic b_busy, b_done, b_error, b_in_ready, b_ram_sel, b_wr_en, b_rd_en, b_stg_start, b_out_valid, b_stg_done;
  logic [2:0] b_wr_addr, b_rd_addr, b_stg_num;
  logic [127:0] b_wr_data, b_out_data;

  fft_seq #(.TIMEOUT(20)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .busy(a_busy), .done(a_done),
    .error(a_error), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .ram_sel(a_ram_sel), .ram_wr_en(a_wr_en), .ram_wr_addr(a_wr_addr), .ram_wr_data(a_wr_data),
    .ram_rd_en(a_rd_en), .ram_rd_addr(a_rd_addr), .ram_rd_data(ram_rd_data[63:0]),
    .stg_start(a_stg_start), .stg_num(a_stg_num), .stg_done(a_stg_done),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data));

  fft_seq #(.NUMSAMPLES(64), .NUMBANKS(8), .ADDRSIZE(3), .NUMSTAGES(6), .STGW(3), .TIMEOUT(20)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .busy(b_busy), .done(b_done),
    .error(b_error), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data_b),
    .ram_sel(b_ram_sel), .ram_wr_en(b_wr_en), .ram_wr_addr(b_wr_addr), .ram_wr_data(b_wr_data),
    .ram_rd_en(b_rd_en), .ram_rd_addr(b_rd_addr), .ram_rd_data(ram_rd_data),
    .stg_start(b_stg_start), .stg_num(b_stg_num), .stg_done(b_stg_done),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data));

  logic m_wr_en, m_rd_en, m_stg_start, m_out_valid, m_done;
  logic [2:0] m_wr_addr, m_rd_addr, m_stg_num;
  logic [127:0] m_wr_data, m_out_data;
  assign m_wr_en     = use_b ? b_wr_en     : a_wr_en;
  assign m_rd_en     = use_b ? b_rd_en     : a_rd_en;
  assign m_stg_start = use_b ? b_stg_start : a_stg_start;
  assign m_out_valid = use_b ? b_out_valid : a_out_valid;
  assign m_done      = use_b ? b_done      : a_done;
  assign m_wr_addr   = use_b ? b_wr_addr   : a_wr_addr;
  assign m_rd_addr   = use_b ? b_rd_addr   : a_rd_addr;
  assign m_stg_num   = use_b ? b_stg_num   : a_stg_num;
  assign m_wr_data   = use_b ? b_wr_data   : {64'd0, a_wr_data};
  assign m_out_data  = use_b ? b_out_data  : {64'd0, a_out_data};

  logic [127:0] mem [0:7];
  always @(posedge clk) begin
    if (m_wr_en) mem[m_wr_addr] <= m_wr_data;
    if (m_rd_en) ram_rd_data <= mem[m_rd_addr];
  end

  // Stage engine: answers 10 cycles after stg_start, except for stage hold_stg.
  int   hold_stg = -1;
  int   eng_cnt  = 0;
  logic eng_done = 1'b0;
  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (m_stg_start) eng_cnt <= (int'(m_stg_num) == hold_stg) ? 0 : 10;
    else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
    if (!m_stg_start && eng_cnt == 2) eng_done <= 1'b1;
  end
  assign a_stg_done = (eng_done | man_done) & !use_b;
  assign b_stg_done = (eng_done | man_done) & use_b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_addr_q[$], rd_q[$], stg_q[$];
  logic [127:0] wr_data_q[$], out_q[$];
  int done_cnt, rd_cnt, pop_cnt, max_out, stab_viol, first_rd, first_val;
  logic prev_stall;
  logic [127:0] prev_data;

  initial forever begin
    @(negedge clk);
    if (m_wr_en) begin wr_addr_q.push_back(int'(m_wr_addr)); wr_data_q.push_back(m_wr_data); end
    if (m_rd_en) begin rd_q.push_back(int'(m_rd_addr)); rd_cnt++; if (first_rd < 0) first_rd = cyc; end
    if (m_stg_start) stg_q.push_back(int'(m_stg_num));
    if (m_out_valid && first_val < 0) first_val = cyc;
    if (m_out_valid && out_ready) begin out_q.push_back(m_out_data); pop_cnt++; end
    if (rd_cnt - pop_cnt > max_out) max_out = rd_cnt - pop_cnt;
    if (prev_stall && (!m_out_valid || m_out_data !== prev_data)) stab_viol++;
    prev_stall = m_out_valid && !out_ready;
    prev_data  = m_out_data;
    if (m_done) done_cnt++;
  end

  int vec = 0, miss = 0;

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_q.delete(); stg_q.delete(); out_q.delete();
    done_cnt = 0; rd_cnt = 0; pop_cnt = 0; max_out = 0; stab_viol = 0;
    first_rd = -1; first_val = -1; prev_stall = 1'b0;
  endtask

  task automatic pulse_start(input bit b);
    @(posedge clk); #1;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic load_beats(input bit stall, output int lows, output int acc);
    lows = 0; acc = 0;
    for (int c = 0; c < 64 && acc < 8; c++) begin
      in_valid = stall ? (c % 2 == 0) : 1'b1;
      in_data  = {4{16'(acc)}};
      @(negedge clk);
      if (!(use_b ? b_in_ready : a_in_ready)) lows++;
      if (in_valid && (use_b ? b_in_ready : a_in_ready)) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_to_done(input bit bp, output bit ok);
    logic [5:0] pat;
    pat = 6'b011001;
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      out_ready = bp ? pat[c % 6] : 1'b1;
      @(negedge clk);
      if (use_b ? b_done : a_done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [9:0] got;
    @(posedge clk); @(posedge clk); @(negedge clk);
    got = {a_busy, a_done, a_error, a_in_ready, a_ram_sel, a_wr_en, a_rd_en, a_stg_start, a_out_valid, 1'b0};
    vec++; if (got !== 10'b0000100000) begin miss++; $display("FAIL reset_a_flags: got %b, expected %b", got, 10'b0000100000); end
    got = {b_busy, b_done, b_error, b_in_ready, b_ram_sel, b_wr_en, b_rd_en, b_stg_start, b_out_valid, 1'b0};
    vec++; if (got !== 10'b0000100000) begin miss++; $display("FAIL reset_b_flags: got %b, expected %b", got, 10'b0000100000); end
    vec++; if ({a_stg_num, a_wr_addr, a_rd_addr} !== 9'd0) begin miss++; $display("FAIL reset_a_counters: got %h, expected 0", {a_stg_num, a_wr_addr, a_rd_addr}); end
    vec++; if (a_out_data !== 64'd0) begin miss++; $display("FAIL reset_a_out_data: got %h, expected 0", a_out_data); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    vec++; if (a_busy !== 1'b0 || a_ram_sel !== 1'b1) begin miss++; $display("FAIL after_reset_idle: busy=%b ram_sel=%b, expected busy=0 ram_sel=1", a_busy, a_ram_sel); end
  endtask

  task automatic test_full_run(input bit b);
    int lows, acc, nst;
    bit ok;
    logic [127:0] exp;
    use_b = b; clear_logs(); nst = b ? 6 : 5;
    pulse_start(b);
    load_beats(1'b0, lows, acc);
    run_to_done(1'b0, ok);
    vec++; if (!ok) begin miss++; $display("FAIL full_run%0d_done: done not seen within 600 cycles, expected a pulse", b); end
    @(negedge clk);
    vec++; if ((b ? b_busy : a_busy) !== 1'b0) begin miss++; $display("FAIL full_run%0d_busy_after_done: got 1, expected 0", b); end
    vec++; if (stg_q.size() != nst) begin miss++; $display("FAIL full_run%0d_stage_count: got %0d, expected %0d", b, stg_q.size(), nst); end
    for (int i = 0; i < stg_q.size() && i < nst; i++) begin
      vec++; if (stg_q[i] != i) begin miss++; $display("FAIL full_run%0d_stg_num[%0d]: got %0d, expected %0d", b, i, stg_q[i], i); end
    end
    vec++; if (rd_q.size() != 8) begin miss++; $display("FAIL full_run%0d_read_count: got %0d, expected 8", b, rd_q.size()); end
    for (int i = 0; i < rd_q.size() && i < 8; i++) begin
      vec++; if (rd_q[i] != i) begin miss++; $display("FAIL full_run%0d_rd_addr[%0d]: got %0d, expected %0d", b, i, rd_q[i], i); end
    end
    vec++; if (out_q.size() != 8) begin miss++; $display("FAIL full_run%0d_beat_count: got %0d, expected 8", b, out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 8; i++) begin
      exp = b ? {8{16'(i)}} : {64'd0, {4{16'(i)}}};
      vec++; if (out_q[i] !== exp) begin miss++; $display("FAIL full_run%0d_beat[%0d]: got %h, expected %h", b, i, out_q[i], exp); end
    end
    vec++; if (done_cnt != 1) begin miss++; $display("FAIL full_run%0d_done_pulses: got %0d, expected 1", b, done_cnt); end
    vec++; if (first_val - first_rd != 2) begin miss++; $display("FAIL full_run%0d_first_valid_latency: got %0d, expected 2", b, first_val - first_rd); end
  endtask

  task automatic test_input_stall();
    int lows, acc;
    bit ok;
    use_b = 1'b0; clear_logs();
    pulse_start(1'b0);
    load_beats(1'b1, lows, acc);
    vec++; if (lows != 0) begin miss++; $display("FAIL stall_in_ready_low: got %0d low cycles in LOAD, expected 0", lows); end
    vec++; if (wr_addr_q.size() != 8) begin miss++; $display("FAIL stall_write_count: got %0d, expected 8", wr_addr_q.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < 8; i++) begin
      vec++; if (wr_addr_q[i] != i || wr_data_q[i] !== {64'd0, {4{16'(i)}}}) begin
        miss++; $display("FAIL stall_write[%0d]: got addr %0d data %h, expected addr %0d", i, wr_addr_q[i], wr_data_q[i], i);
      end
    end
    run_to_done(1'b0, ok);
    vec++; if (!ok) begin miss++; $display("FAIL stall_done: done not seen, expected a pulse"); end
  endtask

  task automatic test_backpressure();
    int lows, acc;
    bit ok;
    use_b = 1'b0; clear_logs();
    pulse_start(1'b0);
    load_beats(1'b0, lows, acc);
    run_to_done(1'b1, ok);
    vec++; if (!ok) begin miss++; $display("FAIL bp_done: done not seen, expected a pulse"); end
    vec++; if (out_q.size() != 8) begin miss++; $display("FAIL bp_beat_count: got %0d, expected 8", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 8; i++) begin
      vec++; if (out_q[i] !== {64'd0, {4{16'(i)}}}) begin miss++; $display("FAIL bp_beat[%0d]: got %h, expected %h", i, out_q[i], {64'd0, {4{16'(i)}}}); end
    end
    vec++; if (stab_viol != 0) begin miss++; $display("FAIL bp_hold_stable: got %0d changes while stalled, expected 0", stab_viol); end
    vec++; if (max_out > 2) begin miss++; $display("FAIL bp_outstanding: got %0d, expected at most 2", max_out); end
  endtask

  task automatic test_watchdog();
    int lows, acc, wd;
    bit ok;
    use_b = 1'b0; clear_logs(); hold_stg = 2;
    pulse_start(1'b0);
    load_beats(1'b0, lows, acc);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (a_stg_start && a_stg_num == 3'd2) begin ok = 1'b1; break; end
    end
    vec++; if (!ok) begin miss++; $display("FAIL wdog_stage2_start: not seen, expected stg_start for stage 2"); end
    wd = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (a_error) begin wd = k; break; end
    end
    vec++; if (wd != 20) begin miss++; $display("FAIL wdog_latency: error after %0d cycles, expected 20", wd); end
    vec++; if (a_busy !== 1'b0) begin miss++; $display("FAIL wdog_busy: got %b, expected 0", a_busy); end
    repeat (3) @(negedge clk);
    vec++; if (a_error !== 1'b1) begin miss++; $display("FAIL wdog_sticky: got %b, expected 1", a_error); end
    pulse_start(1'b0);
    @(negedge clk);
    vec++; if ({a_error, a_in_ready, a_busy} !== 3'b011) begin miss++; $display("FAIL wdog_restart: got error/in_ready/busy %b, expected 011", {a_error, a_in_ready, a_busy}); end
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    hold_stg = -1;
  endtask

  task automatic test_abort();
    int lows, acc, s_stg, s_rd, s_wr;
    bit ok;
    use_b = 1'b0; clear_logs(); hold_stg = 1;
    pulse_start(1'b0);
    load_beats(1'b0, lows, acc);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (a_stg_start && a_stg_num == 3'd1) begin ok = 1'b1; break; end
    end
    vec++; if (!ok) begin miss++; $display("FAIL abort_stage1_start: not seen, expected stg_start for stage 1"); end
    repeat (3) @(negedge clk);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    vec++; if ({a_busy, a_error} !== 2'b00) begin miss++; $display("FAIL abort_to_idle: got busy/error %b, expected 00", {a_busy, a_error}); end
    s_stg = stg_q.size(); s_rd = rd_cnt; s_wr = wr_addr_q.size();
    @(posedge clk); #1; man_done = 1'b1;
    @(posedge clk); #1; man_done = 1'b0;
    repeat (15) @(negedge clk);
    vec++; if (a_busy !== 1'b0) begin miss++; $display("FAIL abort_late_done: busy=%b, expected 0", a_busy); end
    vec++; if (stg_q.size() != s_stg || rd_cnt != s_rd || wr_addr_q.size() != s_wr) begin
      miss++; $display("FAIL abort_quiet: stg/rd/wr grew %0d/%0d/%0d, expected 0/0/0", stg_q.size() - s_stg, rd_cnt - s_rd, wr_addr_q.size() - s_wr);
    end
    @(posedge clk); #1; start_a = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start_a = 1'b0; abort = 1'b0;
    @(negedge clk);
    vec++; if ({a_busy, a_in_ready} !== 2'b00) begin miss++; $display("FAIL abort_beats_start: got busy/in_ready %b, expected 00", {a_busy, a_in_ready}); end
    hold_stg = -1;
  endtask

  task automatic test_async_reset();
    int lows, acc;
    bit ok;
    use_b = 1'b0; clear_logs(); out_ready = 1'b0;
    pulse_start(1'b0);
    load_beats(1'b0, lows, acc);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rd_cnt >= 2) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    vec++; if (!ok || a_out_valid !== 1'b1) begin miss++; $display("FAIL areset_buffered: out_valid=%b reached=%0d, expected 1 with two reads issued", a_out_valid, ok); end
    #1; rst_n = 1'b0; #1;
    vec++; if ({a_out_valid, a_busy, a_ram_sel} !== 3'b001) begin miss++; $display("FAIL areset_immediate: got out_valid/busy/ram_sel %b, expected 001", {a_out_valid, a_busy, a_ram_sel}); end
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    vec++; if ({a_out_valid, a_busy} !== 2'b00) begin miss++; $display("FAIL areset_release: got out_valid/busy %b, expected 00", {a_out_valid, a_busy}); end
  endtask

  initial begin
    test_reset();
    test_full_run(1'b0);
    test_input_stall();
    test_backpressure();
    test_watchdog();
    test_abort();
    test_async_reset();
    test_full_run(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
